std_fp_div_pipe_32_32_0_1: RTL and testbench
============================================

# std_fp_div_pipe_32_32_0_1

Multi-cycle fixed-point divider, the inverse-operation partner of the team's pipelined multiplier. It takes a dividend and a divisor under the same go/done handshake, runs a radix-2 restoring division for WIDTH+FRAC_WIDTH iterations, and returns the quotient and remainder. It is instantiated by generated controllers wherever a `div`/`rem` primitive is scheduled.

## Interface
- WIDTH, 32, operand and result width in bits.
- INT_WIDTH, 32, integer bits of the fixed-point format; INT_WIDTH + FRAC_WIDTH = WIDTH.
- FRAC_WIDTH, 0, fractional bits; the dividend is pre-shifted left by FRAC_WIDTH.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low (asserted at 0); all state clears immediately.
- go  input  1  start request; must stay high until done.
- left  input  WIDTH  dividend, sampled on the accepting edge.
- right  input  WIDTH  divisor, sampled on the accepting edge.
- out_quotient  output  WIDTH  quotient; reset value 0.
- out_remainder  output  WIDTH  remainder; reset value 0.
- done  output  1  one-cycle completion pulse; reset value 0.

## Operation
- FSM states: IDLE, BUSY, FIX, DONE; reset state is IDLE.
- IDLE: if go=1, latch operand magnitudes and signs, clear the partial remainder, load the iteration counter with N = WIDTH+FRAC_WIDTH, then go to BUSY.
- BUSY: each cycle, shift {rem, quo} left by 1 and trial-subtract |divisor|. If rem ≥ |divisor|, keep the difference and set the quotient LSB; otherwise restore. Decrement the counter; at 0, go to FIX.
- FIX: apply signs (SIGNED=1 only). The quotient is negated when the operand signs differ. The remainder takes the dividend's sign. Register the results into out_quotient and out_remainder, then go to DONE.
- DONE: done=1 for this cycle only, then go to IDLE. If go is still high in IDLE, a new operation starts; the controller drops go after done.
- Rounding: the quotient truncates toward zero.
- Divide by zero: out_quotient = all ones, out_remainder = dividend (original, unsigned/signed as given).
- Overflow (SIGNED, MIN / -1): out_quotient = MIN, out_remainder = 0. The magnitude arithmetic uses WIDTH+1 bits internally so |MIN| is representable.
- go low in BUSY or FIX: abort to IDLE next edge. done stays 0, and out_quotient/out_remainder keep their previous values.
- Outputs change only in FIX or on reset; they are held between operations.

## Timing
- Accepting edge E0 (IDLE, go=1) → BUSY for edges E1..EN → FIX at E(N+1) → done=1 during the cycle after E(N+2).
- done rises N+2 edges after E0: 34 edges for the default.
- Results are valid in the same cycle done=1 and remain valid until the next FIX.
- Reset asserted at any time forces IDLE, clears outputs to 0 and drops done asynchronously. The first accept is possible on the first edge after release.
- Operand changes after E0 have no effect on the running operation.

## Configuration
- STD_FP_DIV_ZERO_EARLY_EN defined: a zero divisor detected in IDLE bypasses BUSY. The FSM goes IDLE→FIX→DONE, so done rises 2 edges after E0, with the divide-by-zero results above.
- Undefined: a zero divisor runs the full N iterations. Results are identical; only latency differs.

## Test plan
- left=100, right=7, go held → out_quotient=14, out_remainder=2, done pulses exactly once, 34 edges after accept.
- SIGNED: left=0xFFFFFFF9 (-7), right=2 → out_quotient=0xFFFFFFFD (-3), out_remainder=0xFFFFFFFF (-1). Same test with SIGNED=0 → out_quotient=0x7FFFFFFC, out_remainder=1.
- left=5, right=0 → out_quotient=0xFFFFFFFF, out_remainder=5. Latency is 34 edges without the macro and 2 edges with STD_FP_DIV_ZERO_EARLY_EN.
- left=0x80000000, right=0xFFFFFFFF (SIGNED) → out_quotient=0x80000000, out_remainder=0.
- Complete 100/7, then start 9/3 and drop go at edge 10 → no done pulse, outputs stay 14/2, FSM in IDLE.
- Assert reset at edge 20 of an operation → done=0 and outputs=0 immediately. A fresh 9/3 after release → 3/0, 34 edges after accept.

Source files
------------

// File: rtl/std_fp_div_pipe_32_32_0_1_if.sv
// Handshake/data bundle for the fixed-point divider.
//   go, left, right                     : controller -> divider (master drives)
//   out_quotient, out_remainder, done   : divider -> controller (slave drives)
interface std_fp_div_pipe_32_32_0_1_if #(
    parameter int WIDTH = 32
);
    logic             go;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             done;

    modport master (
        output go, left, right,
        input  out_quotient, out_remainder, done
    );

    modport slave (
        input  go, left, right,
        output out_quotient, out_remainder, done
    );
endinterface

// File: rtl/std_fp_div_pipe_32_32_0_1.sv
// Multi-cycle fixed-point divider (radix-2 restoring, WIDTH+FRAC_WIDTH iterations).
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low; clears FSM and outputs
//   bus    : slave side of std_fp_div_pipe_32_32_0_1_if
//            go (hold until done), left (dividend), right (divisor),
//            out_quotient, out_remainder, done (one-cycle pulse)
// Optional macro STD_FP_DIV_ZERO_EARLY_EN: a zero divisor skips the iterations
// and finishes 2 edges after accept instead of WIDTH+FRAC_WIDTH+2.
module std_fp_div_pipe_32_32_0_1 #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 32,
    parameter int FRAC_WIDTH = 0,
    parameter int SIGNED     = 1
) (
    input logic clk,
    input logic reset,
    std_fp_div_pipe_32_32_0_1_if.slave bus
);
    localparam int N  = WIDTH + FRAC_WIDTH;
    // Quotient result width; INT_WIDTH + FRAC_WIDTH equals WIDTH.
    localparam int QW = INT_WIDTH + FRAC_WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;        // partial remainder, always < |divisor|
    logic [N-1:0]     quo;        // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs;        // |divisor|
    logic [WIDTH-1:0] orig_left;  // dividend as given, for the divide-by-zero remainder
    logic             sign_l;
    logic             sign_r;
    logic             div_zero;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;
    logic             done_r;

    // Operand magnitudes. A WIDTH-bit unsigned holds |MIN| exactly.
    logic             l_neg, r_neg;
    logic [WIDTH-1:0] l_mag, r_mag;
    always_comb begin
        l_neg = (SIGNED != 0) && bus.left[WIDTH-1];
        r_neg = (SIGNED != 0) && bus.right[WIDTH-1];
        l_mag = l_neg ? -bus.left  : bus.left;
        r_mag = r_neg ? -bus.right : bus.right;
    end

    // One restoring step. rem < dvs keeps the shifted value inside WIDTH+1 bits,
    // so the borrow out of the subtraction is the "less than" flag.
    logic [WIDTH:0] rem_sh, diff;
    logic           ge;
    always_comb begin
        rem_sh = {rem, quo[N-1]};
        diff   = rem_sh - {1'b0, dvs};
        ge     = ~diff[WIDTH];
    end

    // Sign fix-up; the remainder follows the dividend's sign.
    logic [WIDTH-1:0] q_mag, q_res, r_res;
    always_comb begin
        q_mag = quo[QW-1:0];
        if (div_zero) begin
            q_res = '1;
            r_res = orig_left;
        end else begin
            q_res = (sign_l ^ sign_r) ? -q_mag : q_mag;
            r_res = sign_l ? -rem : rem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            orig_left <= '0;
            sign_l    <= 1'b0;
            sign_r    <= 1'b0;
            div_zero  <= 1'b0;
            q_out     <= '0;
            r_out     <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        quo       <= N'(l_mag) << FRAC_WIDTH;
                        rem       <= '0;
                        dvs       <= r_mag;
                        orig_left <= bus.left;
                        sign_l    <= l_neg;
                        sign_r    <= r_neg;
                        div_zero  <= (bus.right == '0);
`ifdef STD_FP_DIV_ZERO_EARLY_EN
                        // Zero iterations: BUSY sees cnt==0 on its first edge and
                        // hands straight to FIX, so done lands 2 edges after accept.
                        cnt       <= (bus.right == '0) ? '0 : CW'(N);
`else
                        cnt       <= CW'(N);
`endif
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.go) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                        quo <= {quo[N-2:0], ge};
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    if (!bus.go) begin
                        state <= IDLE;
                    end else begin
                        q_out  <= q_res;
                        r_out  <= r_res;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_quotient  = q_out;
    assign bus.out_remainder = r_out;
    assign bus.done          = done_r;
endmodule

// File: tb/tb_std_fp_div_pipe_32_32_0_1.sv
module tb_std_fp_div_pipe_32_32_0_1;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [31:0] left = '0;
    logic [31:0] right = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    std_fp_div_pipe_32_32_0_1_if #(.WIDTH(32)) bus_s ();
    std_fp_div_pipe_32_32_0_1_if #(.WIDTH(32)) bus_u ();

    assign bus_s.go = go;
    assign bus_s.left = left;
    assign bus_s.right = right;
    assign bus_u.go = go;
    assign bus_u.left = left;
    assign bus_u.right = right;

    std_fp_div_pipe_32_32_0_1 #(.WIDTH(32), .INT_WIDTH(32), .FRAC_WIDTH(0), .SIGNED(1)) dut_s (
        .clk(clk), .reset(rst_n), .bus(bus_s)
    );
    std_fp_div_pipe_32_32_0_1 #(.WIDTH(32), .INT_WIDTH(32), .FRAC_WIDTH(0), .SIGNED(0)) dut_u (
        .clk(clk), .reset(rst_n), .bus(bus_u)
    );

    // Reference: integer division truncating toward zero, remainder with the
    // dividend's sign, divide-by-zero gives all ones / original dividend.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb, q, m;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        m = sa % sb;
        return {q[31:0], m[31:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef STD_FP_DIV_ZERO_EARLY_EN
        return (b == 32'd0) ? 2 : 34;
`else
        return (b == 32'd0) ? 34 : 34;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Run one full operation on both instances, checking latency and results.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] es, eu;
        int lat;
        es = model(a, b, 1'b1);
        eu = model(a, b, 1'b0);
        @(negedge clk);
        go = 1'b1; left = a; right = b;
        @(posedge clk);
        #1;
        left = $urandom; right = $urandom;  // must not disturb the running op
        lat = 0;
        while (bus_s.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat(b)));
        chk("done_u", {31'd0, bus_u.done}, 32'd1);
        chk("quo_s", bus_s.out_quotient, es[63:32]);
        chk("rem_s", bus_s.out_remainder, es[31:0]);
        chk("quo_u", bus_u.out_quotient, eu[63:32]);
        chk("rem_u", bus_u.out_remainder, eu[31:0]);
        @(negedge clk);
        go = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse", {31'd0, bus_s.done}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] a, b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'd0, bus_s.done}, 32'd0);
        chk("rst_quo", bus_s.out_quotient, 32'd0);
        chk("rst_rem", bus_u.out_remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_op(32'd100, 32'd7);
        do_op(32'hFFFF_FFF9, 32'd2);
        do_op(32'd5, 32'd0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF);
        do_op(32'hFFFF_FFF9, 32'd0);
        do_op(32'd100, 32'd7);

        // Abort: go dropped mid-iteration, outputs must hold 14/2
        @(negedge clk);
        go = 1'b1; left = 32'd9; right = 32'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus_s.done === 1'b1 || bus_u.done === 1'b1) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        chk("abort_quo", bus_s.out_quotient, 32'd14);
        chk("abort_rem", bus_s.out_remainder, 32'd2);
        do_op(32'd9, 32'd3);

        // Reset mid-operation: outputs clear without waiting for a clock edge
        do_op(32'd100, 32'd7);
        @(negedge clk);
        go = 1'b1; left = 32'd9; right = 32'd3;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_done", {31'd0, bus_s.done}, 32'd0);
        chk("arst_quo", bus_s.out_quotient, 32'd0);
        chk("arst_rem", bus_s.out_remainder, 32'd0);
        chk("arst_quo_u", bus_u.out_quotient, 32'd0);
        @(negedge clk);
        go = 1'b0;
        rst_n = 1'b1;
        do_op(32'd9, 32'd3);

        // Randomized operands, biased toward the interesting divisors
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            do_op(a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
